// File: rtl/flatten_fc_seq_ctrl.sv
// Sequencer that gathers one image of pixels, streams the flattened vector bit-plane by
// bit-plane through the CIM tiles, then hands the result to the function unit.
module flatten_fc_seq_ctrl #(
   parameter int DATA_SIZE      = 8,
   parameter int INPUT_CHANNELS = 16,
   parameter int IMG_SIZE       = 784,
   parameter int XBAR_SIZE      = 128,
   parameter int BUS_WIDTH      = 16,
   parameter int H_CIM_TILES    = 1,
   localparam int V_CIM_TILES   = (INPUT_CHANNELS*IMG_SIZE + XBAR_SIZE - 1) / XBAR_SIZE,
   localparam int NUM_ADDR_RAW  = (INPUT_CHANNELS*IMG_SIZE + BUS_WIDTH*V_CIM_TILES - 1)
                                  / (BUS_WIDTH*V_CIM_TILES),
   localparam int NUM_ADDR      = (NUM_ADDR_RAW < 1) ? 1 : NUM_ADDR_RAW,
   localparam int COUNT_WIDTH   = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1,
   localparam int ADDR_WIDTH    = (NUM_ADDR > 1) ? $clog2(NUM_ADDR) : 1,
   localparam int PIX_WIDTH     = (IMG_SIZE > 1) ? $clog2(IMG_SIZE) : 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_start,
   output logic                   o_ready,
   input  logic [H_CIM_TILES-1:0] i_cim_ready,
   output logic                   o_cim_we,
   output logic [H_CIM_TILES-1:0] o_cim_start,
   output logic [ADDR_WIDTH-1:0]  o_addr,
   output logic [COUNT_WIDTH-1:0] o_count,
   input  logic                   i_func_ready,
   output logic                   o_func_start,
   output logic                   o_busy
);

   localparam logic [PIX_WIDTH-1:0]   PIX_LAST   = PIX_WIDTH'(IMG_SIZE - 1);
   localparam logic [ADDR_WIDTH-1:0]  ADDR_LAST  = ADDR_WIDTH'(NUM_ADDR - 1);
   localparam logic [COUNT_WIDTH-1:0] COUNT_LAST = COUNT_WIDTH'(DATA_SIZE - 1);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      CONSUME = 3'd1,
      START   = 3'd2,
      WAIT    = 3'd3,
      FUNC    = 3'd4
   } state_t;

   state_t                 state_reg, state_next;
   logic [PIX_WIDTH-1:0]   pix_cnt_reg, pix_cnt_next;
   logic [ADDR_WIDTH-1:0]  addr_reg, addr_next;
   logic [COUNT_WIDTH-1:0] count_reg, count_next;
   logic [H_CIM_TILES-1:0] busy_seen_reg, busy_seen_next;
   logic [H_CIM_TILES-1:0] tile_done;
   logic                   all_ready;
   logic                   idle_ready;

   // A tile counts as started once it has been seen busy at any point in START.
   for (genvar gi = 0; gi < H_CIM_TILES; gi++) begin : g_tile
      assign tile_done[gi] = busy_seen_reg[gi] | ~i_cim_ready[gi];
   end

   assign all_ready  = &i_cim_ready;
   assign idle_ready = !(pix_cnt_reg == PIX_LAST && !all_ready);
   assign o_addr     = addr_reg;
   assign o_count    = count_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= IDLE;
         pix_cnt_reg   <= '0;
         addr_reg      <= '0;
         count_reg     <= '0;
         busy_seen_reg <= '0;
      end else begin
         state_reg     <= state_next;
         pix_cnt_reg   <= pix_cnt_next;
         addr_reg      <= addr_next;
         count_reg     <= count_next;
         busy_seen_reg <= busy_seen_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      pix_cnt_next   = pix_cnt_reg;
      addr_next      = addr_reg;
      count_next     = count_reg;
      busy_seen_next = busy_seen_reg;
      o_ready        = 1'b0;
      o_busy         = 1'b0;
      o_cim_we       = 1'b0;
      o_cim_start    = '0;
      o_func_start   = 1'b0;

      case (state_reg)
         IDLE: begin
            // rst term keeps o_ready high during reset even for single-pixel images
            o_ready        = rst || idle_ready;
            addr_next      = '0;
            count_next     = '0;
            busy_seen_next = '0;
            if (i_start && idle_ready) begin
               if (pix_cnt_reg == PIX_LAST) begin
                  pix_cnt_next = '0;
                  state_next   = CONSUME;
               end else begin
                  pix_cnt_next = pix_cnt_reg + 1'b1;
               end
            end
         end
         CONSUME: begin
            o_busy   = 1'b1;
            o_cim_we = 1'b1;
            if (addr_reg != ADDR_LAST) begin
               addr_next = addr_reg + 1'b1;
            end else begin
               addr_next  = '0;
               state_next = START;
            end
         end
         START: begin
            o_busy         = 1'b1;
            o_cim_start    = ~busy_seen_reg;
            busy_seen_next = busy_seen_reg | ~i_cim_ready;
            if (&tile_done) begin
               busy_seen_next = '0;
               state_next     = WAIT;
            end
         end
         WAIT: begin
            o_busy = 1'b1;
            if (all_ready) begin
               if (count_reg != COUNT_LAST) begin
                  count_next = count_reg + 1'b1;
                  state_next = CONSUME;
               end else begin
                  state_next = FUNC;
               end
            end
         end
         FUNC: begin
            o_busy       = 1'b1;
            o_func_start = i_func_ready;
            if (i_func_ready) begin
               count_next = '0;
               state_next = IDLE;
            end
         end
         default: begin
            state_next     = IDLE;
            pix_cnt_next   = '0;
            addr_next      = '0;
            count_next     = '0;
            busy_seen_next = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_flatten_fc_seq_ctrl.sv
// Directed bench for flatten_fc_seq_ctrl with 4 pixels, 4 addresses, 2 bit planes, 2 tiles.
module tb_flatten_fc_seq_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       i_start;
   logic       o_ready;
   logic [1:0] i_cim_ready;
   logic       o_cim_we;
   logic [1:0] o_cim_start;
   logic [1:0] o_addr;
   logic [0:0] o_count;
   logic       i_func_ready;
   logic       o_func_start;
   logic       o_busy;

   int total = 0;
   int bad   = 0;

   // Tile model: a tile drops ready once it has seen start for lat cycles, stays busy 2 more.
   logic [1:0] cim_mask = 2'b11;
   logic [1:0] tile_rdy;
   int         seen[2]     = '{0, 0};
   int         busy_cnt[2] = '{0, 0};
   int         lat[2]      = '{0, 0};

   always #5 clk = ~clk;

   flatten_fc_seq_ctrl #(
      .DATA_SIZE(2), .INPUT_CHANNELS(1), .IMG_SIZE(4),
      .XBAR_SIZE(4), .BUS_WIDTH(1), .H_CIM_TILES(2)
   ) dut (
      .clk(clk), .rst(rst), .i_start(i_start), .o_ready(o_ready),
      .i_cim_ready(i_cim_ready), .o_cim_we(o_cim_we), .o_cim_start(o_cim_start),
      .o_addr(o_addr), .o_count(o_count), .i_func_ready(i_func_ready),
      .o_func_start(o_func_start), .o_busy(o_busy)
   );

   always @(posedge clk) begin
      for (int t = 0; t < 2; t++) begin
         if (o_cim_start[t]) seen[t] <= seen[t] + 1;
         else                seen[t] <= 0;
         if (o_cim_start[t] && seen[t] >= lat[t]) busy_cnt[t] <= 2;
         else if (busy_cnt[t] > 0)                busy_cnt[t] <= busy_cnt[t] - 1;
      end
   end

   always_comb begin
      tile_rdy = 2'b11;
      for (int t = 0; t < 2; t++)
         if ((o_cim_start[t] && seen[t] >= lat[t]) || busy_cnt[t] > 0) tile_rdy[t] = 1'b0;
   end
   assign i_cim_ready = cim_mask & tile_rdy;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Packed view: ready busy we start[1:0] func_start addr[1:0] count
   task automatic expect_out(input string tag, input logic rdy, input logic bsy,
                             input logic we, input logic [1:0] st, input logic fs,
                             input logic [1:0] ad, input logic cn);
      chk(tag, {o_ready, o_busy, o_cim_we, o_cim_start, o_func_start, o_addr, o_count},
          {rdy, bsy, we, st, fs, ad, cn});
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_image();
      i_start = 1'b1;
      repeat (4) step();
      i_start = 1'b0;
   endtask

   task automatic run_to_idle(input string tag);
      int n  = 0;
      int fs = 0;
      while (o_busy && n < 300) begin
         if (o_func_start) fs++;
         step();
         n++;
      end
      chk({tag, "_idle"}, o_busy, 0);
      chk({tag, "_fs_pulses"}, fs, 1);
   endtask

   initial begin
      int n;
      rst          = 1'b1;
      i_start      = 1'b0;
      i_func_ready = 1'b1;
      #1;
      expect_out("reset_hold", 1, 0, 0, 2'b00, 0, 2'd0, 0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      expect_out("idle_after_reset", 1, 0, 0, 2'b00, 0, 2'd0, 0);

      // Nominal image, tiles respond immediately
      i_start = 1'b1;
      for (int p = 0; p < 3; p++) begin
         step();
         expect_out("nom_pixel", 1, 0, 0, 2'b00, 0, 2'd0, 0);
      end
      step();
      i_start = 1'b0;
      for (int pass = 0; pass < 2; pass++) begin
         for (int a = 0; a < 4; a++) begin
            expect_out("nom_consume", 0, 1, 1, 2'b00, 0, 2'(a), 1'(pass));
            step();
         end
         expect_out("nom_start", 0, 1, 0, 2'b11, 0, 2'd0, 1'(pass));
         step();
         for (int w = 0; w < 3; w++) begin
            expect_out("nom_wait", 0, 1, 0, 2'b00, 0, 2'd0, 1'(pass));
            step();
         end
      end
      expect_out("nom_func", 0, 1, 0, 2'b00, 1, 2'd0, 1);
      step();
      expect_out("nom_back_idle", 1, 0, 0, 2'b00, 0, 2'd0, 0);

      // Back-pressure on the last pixel
      i_start = 1'b1;
      repeat (3) step();
      cim_mask = 2'b01;
      #1;
      chk("bp_ready_low", o_ready, 0);
      step();
      chk("bp_pix_held", dut.pix_cnt_reg, 3);
      chk("bp_still_idle", o_busy, 0);
      chk("bp_ready_still_low", o_ready, 0);
      cim_mask = 2'b11;
      #1;
      chk("bp_ready_high", o_ready, 1);
      step();
      i_start = 1'b0;
      expect_out("bp_consume", 0, 1, 1, 2'b00, 0, 2'd0, 0);
      run_to_idle("bp");

      // Skewed tiles: tile0 drops 1 cycle into start, tile1 after 3
      lat[0] = 1;
      lat[1] = 3;
      send_image();
      repeat (4) step();
      expect_out("skew_start0", 0, 1, 0, 2'b11, 0, 2'd0, 0);
      step();
      expect_out("skew_start1", 0, 1, 0, 2'b11, 0, 2'd0, 0);
      step();
      expect_out("skew_start2", 0, 1, 0, 2'b10, 0, 2'd0, 0);
      step();
      expect_out("skew_start3", 0, 1, 0, 2'b10, 0, 2'd0, 0);
      step();
      expect_out("skew_wait", 0, 1, 0, 2'b00, 0, 2'd0, 0);
      run_to_idle("skew");
      lat[0] = 0;
      lat[1] = 0;

      // Function unit stalled for 5 cycles
      i_func_ready = 1'b0;
      send_image();
      n = 0;
      while (!(o_cim_start == 2'b11 && o_count == 1'b1) && n < 100) begin
         step();
         n++;
      end
      chk("stall_found_last_start", n < 100, 1);
      repeat (4) step();
      for (int f = 0; f < 5; f++) begin
         expect_out("stall_func_hold", 0, 1, 0, 2'b00, 0, 2'd0, 1);
         step();
      end
      i_func_ready = 1'b1;
      #1;
      expect_out("stall_func_pulse", 0, 1, 0, 2'b00, 1, 2'd0, 1);
      step();
      expect_out("stall_idle", 1, 0, 0, 2'b00, 0, 2'd0, 0);

      // Asynchronous reset in CONSUME at addr 2
      send_image();
      step();
      step();
      expect_out("arst_pre", 0, 1, 1, 2'b00, 0, 2'd2, 0);
      #1;
      rst = 1'b1;
      #1;
      expect_out("arst_immediate", 1, 0, 0, 2'b00, 0, 2'd0, 0);
      step();
      rst = 1'b0;
      i_start = 1'b1;
      repeat (3) step();
      expect_out("arst_pix3_idle", 1, 0, 0, 2'b00, 0, 2'd0, 0);
      step();
      i_start = 1'b0;
      expect_out("arst_consume", 0, 1, 1, 2'b00, 0, 2'd0, 0);
      run_to_idle("arst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
